// File: rtl/eth_pkt_pkg.sv
// Shared types and width helpers for the Ethernet TX packet segmenter.
// The default constants describe the 64-bit build; the helpers cover other widths.
package eth_pkt_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_LAST  = 2'd2
   } pkt_state_t;

   localparam int KEEP_W     = 8;
   localparam int BYTE_SHIFT = 3;

   function automatic int keep_w(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int byte_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/eth_idle_timer.sv
// Idle timer for a partially held packet. After TIMEOUT idle cycles it raises
// flush_pend, which stays set until the held beat is emitted.
module eth_idle_timer
   import eth_pkt_pkg::*;
#(
   parameter int TIMEOUT   = 256,
   parameter int TMR_WIDTH = 16
)
(
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   input  logic i_clr,
   input  logic i_emit,
   output logic o_flush_pend,
   output logic o_timeout
);

   logic [TMR_WIDTH-1:0] r_tmr;
   logic                 r_flush_pend;
   logic                 w_at_limit;

   assign w_at_limit   = (r_tmr == TMR_WIDTH'(TIMEOUT - 1));
   // o_timeout is high in the cycle whose clock edge sets flush_pend.
   assign o_timeout    = i_run && !i_clr && w_at_limit;
   assign o_flush_pend = r_flush_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmr        <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (i_clr) begin
            r_tmr <= '0;
         end else if (i_run) begin
            if (w_at_limit) begin
               r_tmr <= '0;
            end else begin
               r_tmr <= r_tmr + 1'b1;
            end
         end

         if (i_emit) begin
            r_flush_pend <= 1'b0;
         end else if (o_timeout) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_pkt_seg.sv
// Cuts a continuous user AXI-Stream into tx_size-byte packets. A one-beat hold
// register lets tlast be attached late on user tlast, length or idle timeout.
module eth_tx_pkt_seg
   import eth_pkt_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int TIMEOUT         = 256,
   parameter int TMR_WIDTH       = 16
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [15:0]                  tx_size,
   input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   output logic [31:0]                  pkt_cnt,
   output logic [15:0]                  flush_cnt,
   output pkt_state_t                   dbg_state
);

   localparam int LP_KEEP_W = keep_w(AXIS_DATA_WIDTH);
   localparam int LP_SHIFT  = byte_shift(AXIS_DATA_WIDTH);

   pkt_state_t                 r_state;
   logic                       r_hold_last;
   logic [AXIS_DATA_WIDTH-1:0] r_hold_data;
   logic [LP_KEEP_W-1:0]       r_hold_keep;
   logic [15:0]                r_cap_cnt;
   logic [15:0]                r_len_w;
   logic [31:0]                r_pkt_cnt;
   logic [15:0]                r_flush_cnt;

   logic        w_hold_vld;
   logic        w_last;
   logic        w_m_valid;
   logic        w_s_ready;
   logic        w_emit;
   logic        w_cap;
   logic        w_flush_pend;
   logic        w_timeout;
   logic        w_flush_emit;
   logic        w_tmr_run;
   logic [15:0] w_cnt_base;
   logic [15:0] w_new_len;
   logic [15:0] w_len;
   logic        w_cap_last;

   // Both ports use plain AXI-Stream valid/ready: a beat transfers on a clock
   // edge where valid and ready are both high; valid, once raised, holds with
   // its payload until that edge. s_axis_tready combinationally follows
   // m_axis_tready so the hold register can be refilled in the emitting cycle.
   assign w_hold_vld = (r_state != ST_EMPTY);
   assign w_last     = (r_state == ST_LAST);
   assign w_m_valid  = w_hold_vld && (w_last || s_axis_tvalid);
   assign w_emit     = w_m_valid && m_axis_tready;
   assign w_s_ready  = !rst && (!w_hold_vld || w_emit);
   assign w_cap      = s_axis_tvalid && w_s_ready;

   // A timeout-closed packet leaves cap_cnt mid-count; a capture in the same
   // cycle must already count as beat 0 of the next packet.
   assign w_flush_emit = w_emit && w_flush_pend && !r_hold_last;
   assign w_cnt_base   = w_flush_emit ? 16'd0 : r_cap_cnt;
   assign w_new_len    = tx_size >> LP_SHIFT;
   assign w_len        = (w_cnt_base != 16'd0) ? r_len_w :
                         (w_new_len == 16'd0)  ? 16'd1   : w_new_len;
   assign w_cap_last   = s_axis_tlast || ((w_cnt_base + 16'd1) == w_len);

   assign w_tmr_run = w_hold_vld && !r_hold_last && !w_flush_pend && !s_axis_tvalid;

   eth_idle_timer #(
      .TIMEOUT   (TIMEOUT),
      .TMR_WIDTH (TMR_WIDTH)
   ) u_idle_timer (
      .clk          (clk),
      .rst          (rst),
      .i_run        (w_tmr_run),
      .i_clr        (w_cap || w_emit),
      .i_emit       (w_emit),
      .o_flush_pend (w_flush_pend),
      .o_timeout    (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         r_hold_last <= 1'b0;
         r_hold_data <= '0;
         r_hold_keep <= '0;
         r_cap_cnt   <= '0;
         r_len_w     <= '0;
         r_pkt_cnt   <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_cap) begin
            r_state <= w_cap_last ? ST_LAST : ST_HOLD;
         end else if (w_emit) begin
            r_state <= ST_EMPTY;
         end else if (w_timeout) begin
            r_state <= ST_LAST;
         end

         if (w_cap) begin
            r_hold_data <= s_axis_tdata;
            r_hold_keep <= s_axis_tkeep;
            r_hold_last <= w_cap_last;
            r_cap_cnt   <= w_cap_last ? 16'd0 : (w_cnt_base + 16'd1);
            if (w_cnt_base == 16'd0) begin
               r_len_w <= w_len;
            end
         end else if (w_emit) begin
            r_hold_last <= 1'b0;
            if (w_flush_emit) begin
               r_cap_cnt <= 16'd0;
            end
         end

         if (w_emit && w_last) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
         if (w_flush_emit && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tvalid = w_m_valid;
   assign m_axis_tlast  = w_last;
   assign m_axis_tdata  = r_hold_data;
   assign m_axis_tkeep  = r_hold_keep;
   assign pkt_cnt       = r_pkt_cnt;
   assign flush_cnt     = r_flush_cnt;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_eth_tx_pkt_seg.sv
// Bench for eth_tx_pkt_seg: directed segmentation/timeout/reset cases plus a
// randomized backpressure run, checked against a beat-level packet model.
module tb_eth_tx_pkt_seg;
   import eth_pkt_pkg::*;

   localparam int W  = 64;
   localparam int KW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   tx_size = 16'd32;
   logic [W-1:0]  s_data = '0;
   logic [KW-1:0] s_keep = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic [W-1:0]  m_data;
   logic [KW-1:0] m_keep;
   logic          m_valid;
   logic          m_last;
   logic          m_ready = 1'b1;
   logic [31:0]   pkt_cnt;
   logic [15:0]   flush_cnt;
   pkt_state_t    dbg_state;

   eth_tx_pkt_seg #(
      .AXIS_DATA_WIDTH (W),
      .TIMEOUT         (TO),
      .TMR_WIDTH       (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_size       (tx_size),
      .s_axis_tdata  (s_data),
      .s_axis_tkeep  (s_keep),
      .s_axis_tvalid (s_valid),
      .s_axis_tlast  (s_last),
      .s_axis_tready (s_ready),
      .m_axis_tdata  (m_data),
      .m_axis_tkeep  (m_keep),
      .m_axis_tvalid (m_valid),
      .m_axis_tlast  (m_last),
      .m_axis_tready (m_ready),
      .pkt_cnt       (pkt_cnt),
      .flush_cnt     (flush_cnt),
      .dbg_state     (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic rand_rdy = 1'b0;
   always @(posedge clk) begin
      #1;
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // scoreboard: each entry is {tlast, tkeep, tdata}
   logic [W+KW:0] exp_q[$];
   int n_chk  = 0;
   int n_fail = 0;
   int exp_pkt = 0;
   int exp_flush = 0;
   int pos = 0;
   int cur_len = 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Packet rule: length in words comes from tx_size at the first beat of a
   // packet (0 words means 1); user tlast or reaching the length ends it.
   task automatic model_push(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
      logic last;
      if (pos == 0) begin
         cur_len = int'(tx_size) / KW;
         if (cur_len == 0) cur_len = 1;
      end
      last = l || (pos + 1 == cur_len);
      pos  = last ? 0 : pos + 1;
      exp_q.push_back({last, k, d});
   endtask

   // An idle timeout closes the packet at the most recently accepted beat.
   task automatic model_flush();
      logic [W+KW:0] e;
      e = exp_q[exp_q.size()-1];
      e[W+KW] = 1'b1;
      exp_q[exp_q.size()-1] = e;
      pos = 0;
      if (exp_flush < 65535) exp_flush++;
   endtask

   // driver tasks
   task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
      int n = 0;
      s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (!s_ready) begin
         chk("send_wait_ready", 1'b0, 1'b1);
         s_valid = 1'b0; s_last = 1'b0;
         return;
      end
      model_push(d, k, l);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_full(input int n);
      for (int i = 0; i < n; i++) send({$urandom, $urandom}, 8'hFF, 1'b0);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
      @(negedge clk);
      chk({tag, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_pkt));
      chk({tag, "_flush_cnt"}, 128'(flush_cnt), 128'(exp_flush));
      @(posedge clk); #1;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_tvalid"}, m_valid, 1'b0);
      chk({tag, "_tlast"}, m_last, 1'b0);
      chk({tag, "_tdata"}, m_data, '0);
      chk({tag, "_tkeep"}, m_keep, '0);
      chk({tag, "_pkt_cnt"}, pkt_cnt, '0);
      chk({tag, "_flush_cnt"}, flush_cnt, '0);
      chk({tag, "_state"}, dbg_state, ST_EMPTY);
   endtask

   task automatic timeout_case(input string tag);
      int n = 0;
      tx_size = 16'd64;
      send_full(2);
      model_flush();
      do begin
         @(negedge clk);
         n++;
      end while (!m_valid && n < 100);
      chk({tag, "_latency"}, 128'(n), 128'(TO + 1));
      chk({tag, "_tlast"}, m_last, 1'b1);
      drain(tag);
   endtask

   // output monitor: ordering, content, and stability while stalled
   logic          prev_stall = 1'b0;
   logic [W+KW:0] prev_out;
   logic [W+KW:0] mon_e;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_tvalid", m_valid, 1'b1);
            chk("stall_stable", {m_last, m_keep, m_data}, prev_out);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_beat", {m_last, m_keep, m_data}, mon_e);
               if (mon_e[W+KW]) exp_pkt++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_out   = {m_last, m_keep, m_data};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", s_ready, 1'b0);
      check_quiet("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_quiet("post_rst");
      @(posedge clk); #1;

      // length segmentation, back-to-back
      tx_size = 16'd32;
      t0 = cyc;
      send_full(12);
      chk("seg_no_bubbles", 128'(cyc - t0), 128'd12);
      drain("seg");
      chk("seg_three_pkts", pkt_cnt, 32'd3);

      // early user tlast with partial keep, then a full 8-beat packet
      tx_size = 16'd64;
      send_full(2);
      send({$urandom, $urandom}, 8'h0F, 1'b1);
      send_full(8);
      drain("early");

      // idle timeout
      timeout_case("tmo");
      chk("tmo_flush_one", flush_cnt, 16'd1);
      tx_size = 16'd64;
      send_full(8);
      drain("after_tmo");

      // size edge cases
      tx_size = 16'd0;
      send_full(3);
      tx_size = 16'd7;
      send_full(3);
      tx_size = 16'd32;
      send_full(2);
      tx_size = 16'd16;
      send_full(4);
      drain("sizes");

      // random backpressure
      rand_rdy = 1'b1;
      tx_size  = 16'd40;
      for (int i = 0; i < 1000; i++) begin
         send({$urandom, $urandom}, 8'hFF, 1'b0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rand_rdy = 1'b0;
      drain("bp");

      // reset mid-packet
      tx_size = 16'd32;
      send_full(2);
      rst = 1'b1;
      exp_q.delete();
      pos = 0; exp_pkt = 0; exp_flush = 0;
      @(negedge clk);
      chk("midrst_tready", s_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_quiet("midrst_release");
      @(posedge clk); #1;
      send_full(4);
      drain("midrst");
      chk("midrst_one_pkt", pkt_cnt, 32'd1);

      // flush counter saturation
      force dut.r_flush_cnt = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_flush_cnt;
      exp_flush = 65535;
      @(negedge clk);
      chk("sat_preset", flush_cnt, 16'hFFFF);
      @(posedge clk); #1;
      timeout_case("sat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
